// File: rtl/lcd_pkg.sv
// Shared LCD definitions: FSM state encoding, command bytes and default 50 MHz timing.
// The busy-poll states are only reached when LCD_BUSY_POLL_EN is defined.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_EXEC_WAIT,
        ST_DONE,
        ST_POLL_SETUP,
        ST_POLL_E,
        ST_POLL_HOLD
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int unsigned LCD_T_SETUP     = 4;
    localparam int unsigned LCD_T_E_HIGH    = 12;
    localparam int unsigned LCD_T_HOLD      = 2;
    localparam int unsigned LCD_T_EXEC      = 2000;
    localparam int unsigned LCD_T_EXEC_LONG = 82000;
    localparam int unsigned LCD_CNT_W       = 17;

    // Clear/home (0x01..0x03) need the long execution time.
    function automatic logic lcd_is_long(input logic is_cmd, input logic [7:0] db);
        return is_cmd && (db[7:2] == 6'b000000);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by all timed LCD states; holds at zero, never wraps.
module lcd_delay_timer #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 8-bit bus byte writer with setup/E/hold timing and execution wait.
// Define LCD_BUSY_POLL_EN to replace the fixed execution wait with busy-flag polling.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP     = LCD_T_SETUP,
    parameter int unsigned T_E_HIGH    = LCD_T_E_HIGH,
    parameter int unsigned T_HOLD      = LCD_T_HOLD,
    parameter int unsigned T_EXEC      = LCD_T_EXEC,
    parameter int unsigned T_EXEC_LONG = LCD_T_EXEC_LONG,
    parameter int unsigned CNT_W       = LCD_CNT_W
) (
    input  logic       sm_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] DB,
    input  logic       is_command,
    output logic       finished,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in
);

    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_E_HIGH = CNT_W'(T_E_HIGH - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_LONG   = CNT_W'(T_EXEC_LONG - 1);
`ifndef LCD_BUSY_POLL_EN
    localparam logic [CNT_W-1:0] L_EXEC   = CNT_W'(T_EXEC - 1);
`endif

    lcd_state_e       r_state;
    logic             r_long;
    logic             r_finished;
    logic             r_busy;
    logic             r_e;
    logic             r_rs;
    logic             r_rw;
    logic [7:0]       r_data;
    logic             r_oe;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_zero;

`ifdef LCD_BUSY_POLL_EN
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_poll_flag;
    logic             w_to_zero;

    assign w_to_zero = (r_to_cnt == '0);
`else
    logic             w_unused_data_in;

    assign w_unused_data_in = ^lcd_data_in;
`endif

    lcd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (sm_clk),
        .i_reset    (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Timer is loaded on the same edge the FSM enters a timed state.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load = start;
                w_tmr_val  = L_SETUP;
            end
            ST_SETUP: begin
                w_tmr_load = w_tmr_zero;
                w_tmr_val  = L_E_HIGH;
            end
            ST_E_HIGH: begin
                w_tmr_load = w_tmr_zero;
                w_tmr_val  = L_HOLD;
            end
            ST_HOLD: begin
                w_tmr_load = w_tmr_zero;
`ifdef LCD_BUSY_POLL_EN
                w_tmr_val  = L_SETUP;
`else
                w_tmr_val  = r_long ? L_LONG : L_EXEC;
`endif
            end
`ifdef LCD_BUSY_POLL_EN
            ST_POLL_SETUP: begin
                w_tmr_load = w_tmr_zero && !w_to_zero;
                w_tmr_val  = L_E_HIGH;
            end
            ST_POLL_E: begin
                w_tmr_load = w_tmr_zero && !w_to_zero;
                w_tmr_val  = L_HOLD;
            end
            ST_POLL_HOLD: begin
                w_tmr_load = w_tmr_zero && !w_to_zero && r_poll_flag;
                w_tmr_val  = L_SETUP;
            end
`endif
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sm_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_long     <= 1'b0;
            r_finished <= 1'b0;
            r_busy     <= 1'b0;
            r_e        <= 1'b0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
            r_data     <= 8'h00;
            r_oe       <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
            r_to_cnt    <= '0;
            r_poll_flag <= 1'b0;
`endif
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETUP;
                        r_busy  <= 1'b1;
                        r_rs    <= ~is_command;
                        r_rw    <= 1'b0;
                        r_data  <= DB;
                        r_long  <= lcd_is_long(is_command, DB);
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_E_HIGH;
                        r_e     <= 1'b1;
                    end
                end
                ST_E_HIGH: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_HOLD;
                        r_e     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_zero) begin
`ifdef LCD_BUSY_POLL_EN
                        r_state  <= ST_POLL_SETUP;
                        r_rs     <= 1'b0;
                        r_rw     <= 1'b1;
                        r_oe     <= 1'b0;
                        r_to_cnt <= L_LONG;
`else
                        r_state  <= ST_EXEC_WAIT;
`endif
                    end
                end
                ST_EXEC_WAIT: begin
                    if (w_tmr_zero) begin
                        r_state    <= ST_DONE;
                        r_finished <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef LCD_BUSY_POLL_EN
                ST_POLL_SETUP, ST_POLL_E, ST_POLL_HOLD: begin
                    // Timeout spans the whole polling phase, independent of the per-read timer.
                    if (w_to_zero) begin
                        r_state    <= ST_DONE;
                        r_finished <= 1'b1;
                        r_e        <= 1'b0;
                        r_rw       <= 1'b0;
                        r_oe       <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                        if (w_tmr_zero) begin
                            case (r_state)
                                ST_POLL_SETUP: begin
                                    r_state <= ST_POLL_E;
                                    r_e     <= 1'b1;
                                end
                                ST_POLL_E: begin
                                    r_state     <= ST_POLL_HOLD;
                                    r_e         <= 1'b0;
                                    r_poll_flag <= lcd_data_in[7];
                                end
                                default: begin
                                    if (r_poll_flag) begin
                                        r_state <= ST_POLL_SETUP;
                                    end else begin
                                        r_state    <= ST_DONE;
                                        r_finished <= 1'b1;
                                        r_rw       <= 1'b0;
                                        r_oe       <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign finished    = r_finished;
    assign busy        = r_busy;
    assign lcd_e       = r_e;
    assign lcd_rs      = r_rs;
    assign lcd_rw      = r_rw;
    assign lcd_data    = r_data;
    assign lcd_data_oe = r_oe;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer (default fixed-delay build).
module tb_lcd_byte_writer;

    localparam int unsigned S  = 2;
    localparam int unsigned EH = 3;
    localparam int unsigned H  = 1;
    localparam int unsigned X  = 5;
    localparam int unsigned XL = 20;

    logic       sm_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] DB = 8'h00;
    logic       is_command = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic       finished, busy, lcd_e, lcd_rs, lcd_rw, lcd_data_oe;
    logic [7:0] lcd_data;

    int n_vec = 0;
    int n_err = 0;

    lcd_byte_writer #(
        .T_SETUP     (S),
        .T_E_HIGH    (EH),
        .T_HOLD      (H),
        .T_EXEC      (X),
        .T_EXEC_LONG (XL),
        .CNT_W       (17)
    ) dut (
        .sm_clk      (sm_clk),
        .reset       (reset),
        .start       (start),
        .DB          (DB),
        .is_command  (is_command),
        .finished    (finished),
        .busy        (busy),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_data    (lcd_data),
        .lcd_data_oe (lcd_data_oe),
        .lcd_data_in (lcd_data_in)
    );

    always #5 sm_clk = ~sm_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is an offset k (cycles since capture) against a total length.
    bit         m_act = 1'b0;
    int         m_k = 0;
    int         m_len = 0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         chk_en = 1'b0;

    always @(posedge sm_clk) begin
        if (reset) begin
            m_act  = 1'b0;
            m_rs   = 1'b0;
            m_data = 8'h00;
            chk_en = 1'b1;
        end else if (m_act) begin
            m_k++;
            if (m_k > m_len) m_act = 1'b0;
        end else if (start) begin
            m_act  = 1'b1;
            m_k    = 1;
            m_rs   = !is_command;
            m_data = DB;
            m_len  = 1 + S + EH + H + ((is_command && DB <= 8'h03) ? XL : X);
        end
    end

    always @(negedge sm_clk) begin
        if (chk_en) begin
            chk("busy",     busy,     m_act);
            chk("lcd_e",    lcd_e,    m_act && m_k >= S + 1 && m_k <= S + EH);
            chk("finished", finished, m_act && m_k == m_len);
            chk("lcd_rs",   lcd_rs,   m_rs);
            chk("lcd_data", lcd_data, m_data);
            chk("lcd_rw",   lcd_rw,   1'b0);
            chk("lcd_oe",   lcd_data_oe, 1'b1);
        end
    end

    // Starts a transfer in the current (idle) cycle and measures cycles until finished.
    task automatic xfer(input logic [7:0] d, input logic c, input int exp_lat,
                        input int poke_at, input string nm);
        int n;
        bit seen;
        DB = d;
        is_command = c;
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge sm_clk);
            n++;
            start = 1'b0;
            if (n == 1) DB = 8'hA5;
            if (n == poke_at) begin
                start = 1'b1;
                DB = 8'h55;
            end
            if (finished) seen = 1'b1;
        end
        chk(nm, n, exp_lat);
        chk({nm, "_data"}, lcd_data, d);
        start = 1'b0;
        @(negedge sm_clk);
    endtask

    initial begin
        int n;
        int f1;
        int f2;
        int nfin;
        repeat (3) @(negedge sm_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_oe", lcd_data_oe, 1'b1);
        chk("rst_data", lcd_data, 8'h00);
        reset = 1'b0;
        @(negedge sm_clk);

        xfer(8'h41, 1'b0, 12, 0, "lat_data41");
        xfer(8'h01, 1'b1, 27, 0, "lat_clear");
        xfer(8'h03, 1'b1, 27, 0, "lat_cmd03");
        xfer(8'h04, 1'b1, 12, 0, "lat_cmd04");
        xfer(8'h02, 1'b1, 27, 0, "lat_home");
        xfer(8'h01, 1'b0, 12, 0, "lat_data01");
        xfer(8'h41, 1'b0, 12, 6, "lat_busy_start");
        repeat (20) @(negedge sm_clk);

        // Back-to-back with start held high
        DB = 8'h42;
        is_command = 1'b0;
        start = 1'b1;
        n = 0; f1 = 0; f2 = 0;
        while (f2 == 0 && n < 100) begin
            @(negedge sm_clk);
            n++;
            if (finished) begin
                if (f1 == 0) f1 = n;
                else begin
                    f2 = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first", f1, 12);
        chk("b2b_second", f2, 25);
        @(negedge sm_clk);

        // Reset while E is high
        DB = 8'h41;
        is_command = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge sm_clk);
            start = 1'b0;
        end
        chk("mid_e_before", lcd_e, 1'b1);
        reset = 1'b1;
        @(negedge sm_clk);
        reset = 1'b0;
        chk("mid_e_after", lcd_e, 1'b0);
        chk("mid_busy_after", busy, 1'b0);
        nfin = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sm_clk);
            if (finished) nfin++;
        end
        chk("mid_no_finish", nfin, 0);
        xfer(8'h41, 1'b0, 12, 0, "lat_after_reset");

        // Random traffic including mid-transfer input changes and stray resets
        for (int i = 0; i < 2500; i++) begin
            @(negedge sm_clk);
            start = ($urandom_range(0, 3) == 0);
            DB = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            is_command = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge sm_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
